// File: rtl/load_store_unit.sv
// Load/store unit: decodes a memory instruction, issues a single registered
// bus access, waits for bus_ready (or a timeout), and returns the
// lane-extracted load result for one DONE cycle.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        excp,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to represent 0..TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    offset_q;

  logic          is_mem;
  logic          illegal;
  logic          misaligned;
  logic          access;
  logic          timeout_hit;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Decode the instruction: exception, byte enables and replicated store data.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    is_mem     = mem_read | mem_write;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (mem_write && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    excp       = is_mem & (illegal | misaligned);
    access     = is_mem & ~excp;

    // Loads always fetch the full word; only stores narrow the enables.
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        wdata_nxt = {4{wdata[7:0]}};
        if (mem_write) be_nxt = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_nxt = {2{wdata[15:0]}};
        if (mem_write) be_nxt = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    shifted  = bus_rdata >> {offset_q, 3'b000};
    load_ext = bus_rdata;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  // Next-state and stall logic.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    timeout_hit = (wait_cnt == WAIT_LAST) && !bus_ready;
    unique case (state)
      IDLE: begin
        stall = access;
        if (access) state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ready || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset also aborts any access in flight.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus request, latched access attributes, wait counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      funct3_q  <= 3'd0;
      offset_q  <= 2'd0;
      wait_cnt  <= '0;
      load_data <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
            funct3_q  <= funct3;
            offset_q  <= addr[1:0];
            wait_cnt  <= '0;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req   <= 1'b0;
            load_data <= bus_we ? 32'd0 : load_ext;
          end else if (timeout_hit) begin
            bus_req   <= 1'b0;
            load_data <= 32'd0;
            bus_err   <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end
        default: begin
          // DONE: the result is visible for exactly one cycle.
          load_data <= 32'd0;
          bus_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against a behavioural model of the access rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, excp, bus_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .excp(excp), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_excp(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (!(rd || wr)) return 0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
    if (wr && (f3 == 4 || f3 == 5)) return 1;
    sz = (f3 == 2) ? 4 : (f3 == 1 || f3 == 5) ? 2 : 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] model_be(bit wr, logic [2:0] f3, logic [31:0] a);
    int off = a % 4;
    if (!wr) return 4'hF;
    case (f3)
      0: return 4'(1 << off);
      1: return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
    case (f3 % 4)
      0: return (wd & 32'hFF) * 32'h0101_0101;
      1: return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * (a % 4));
    case (f3)
      0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      4: v = sh & 32'hFF;
      1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      5: v = sh & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // One full instruction: IDLE decode, REQ cycles, DONE, back to IDLE.
  // n = wait cycles before bus_ready; n >= TIMEOUT means it never comes.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int n, input logic [31:0] rdata);
    bit          e;
    logic [31:0] exp_ld;
    bit          exp_err;
    e = model_excp(rd, wr, f3, a);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'b0;
    #1;
    check("excp", excp, e);
    check("stall_idle", stall, !e);
    if (e) begin
      @(negedge clk);
      check("no_req_on_excp", bus_req, 0);
      mem_read = 0; mem_write = 0;
      @(negedge clk);
      check("still_no_req", bus_req, 0);
      return;
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      check("req", bus_req, 1);
      check("stall_req", stall, 1);
      check("bus_we", bus_we, wr);
      check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      check("bus_be", bus_be, model_be(wr, f3, a));
      if (wr) check("bus_wdata", bus_wdata, model_wdata(f3, wd));
      check("ld_zero_req", load_data, 0);
      check("err_zero_req", bus_err, 0);
      if (k == n) begin
        bus_ready = 1'b1; bus_rdata = rdata;
        break;
      end
      bus_ready = 1'b0; bus_rdata = $urandom;
    end
    exp_err = (n >= TIMEOUT);
    exp_ld  = (exp_err || wr) ? 32'd0 : model_load(f3, a, rdata);
    // DONE: instruction inputs still asserted, must not start a new access.
    @(negedge clk);
    bus_ready = 1'b0; bus_rdata = $urandom;
    #1;
    check("stall_done", stall, 0);
    check("req_done", bus_req, 0);
    check("load_data", load_data, exp_ld);
    check("bus_err", bus_err, exp_err);
    @(negedge clk);
    check("req_after_done", bus_req, 0);
    check("ld_after_done", load_data, 0);
    check("err_after_done", bus_err, 0);
    mem_read = 0; mem_write = 0;
    #1;
    check("stall_after_done", stall, 0);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h40; bus_ready = 0;
    @(negedge clk);
    check("abort_req_up", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_async", bus_req, 0);
    mem_read = 0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_ld", load_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_req", bus_req, 0);
      check("post_abort_err", bus_err, 0);
      check("post_abort_stall", stall, 0);
    end
  endtask

  initial begin
    mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    #12;
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_ld", load_data, 0);
    check("rst_err", bus_err, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", bus_req, 0);

    run_txn(1, 0, 3'b010, 32'h100, 0, 2, 32'hDEAD_BEEF);   // LW, 2 waits
    run_txn(1, 0, 3'b000, 32'h103, 0, 0, 32'h8012_3456);   // LB
    run_txn(1, 0, 3'b100, 32'h103, 0, 1, 32'h8012_3456);   // LBU
    run_txn(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0);   // SH
    run_txn(1, 0, 3'b010, 32'h101, 0, 0, 0);               // misaligned LW
    run_txn(1, 0, 3'b011, 32'h100, 0, 0, 0);               // illegal funct3
    run_txn(0, 1, 3'b100, 32'h100, 0, 0, 0);               // store BU
    run_txn(1, 1, 3'b001, 32'h203, 0, 0, 0);               // store wins, misaligned
    run_txn(1, 0, 3'b010, 32'h300, 0, 10, 32'h1111_1111);  // timeout
    run_txn(1, 0, 3'b001, 32'h302, 0, TIMEOUT - 1, 32'h9876_5432); // ready on last cycle
    reset_abort();

    for (int t = 0; t < 120; t++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 2) == 0);
      if (!rd && !wr) rd = 1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      run_txn(rd, wr, f3, a, $urandom, $urandom_range(0, TIMEOUT + 1), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on total runtime.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
